matrix_operand_fetch: RTL and testbench

Operand-staging stage feeding the matrix multiplier. Holds matrices A and B in two internal register-file buffers loaded element-by-element by the host. On `start` it streams operand pairs `a_data = A[row][k]`, `b_data = B[k][col]` in the multiplier's row/col/k order, with k fastest, then col, then row. Delivery uses a valid/ready handshake so the downstream stage can stall the stream.

---
 rtl/matrix_operand_fetch.sv | 173 +++++++++++++++++
 tb/tb_matrix_operand_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_fetch.sv
// matrix_operand_fetch: holds matrices A and B in two register-file buffers
// loaded by the host, then streams A[row][k] / B[k][col] operand pairs
// (k fastest, then col, then row) over a valid/ready handshake.
module matrix_operand_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAX_N  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic [3:0]        load_row,
  input  logic [3:0]        load_col,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last_k,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DEPTH  = MAX_N * MAX_N;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   row_q, row_d, col_q, col_d, k_q, k_d;
  logic [DATA_W-1:0]  a_d, b_d;
  logic               valid_d, last_k_d, last_d, busy_d, done_d, err_d;
  logic               load_beat;
  logic               wr_en, start_ok, is_last;
  logic [IDX_W-1:0]   nm1;

  logic [DATA_W-1:0]  buf_a [DEPTH];
  logic [DATA_W-1:0]  buf_b [DEPTH];

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] r,
                                                input logic [IDX_W-1:0] c);
    logic [31:0] full;
    full = 32'(r) * MAX_N + 32'(c);
    return full[ADDR_W-1:0];
  endfunction

  assign wr_en    = load_en && (state_q == IDLE) &&
                    (32'(load_row) < MAX_N) && (32'(load_col) < MAX_N);
  assign start_ok = (matrix_size != '0) && (32'(matrix_size) <= MAX_N);
  assign nm1      = n_q - IDX_W'(1);
  assign is_last  = (row_q == nm1) && (col_q == nm1) && (k_q == nm1);

  // Operand buffers: host writes only in IDLE, contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (load_sel) buf_b[addr_of(load_row, load_col)] <= load_data;
      else          buf_a[addr_of(load_row, load_col)] <= load_data;
    end
  end

  // State, index and registered-output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      a_data     <= '0;
      b_data     <= '0;
      out_valid  <= 1'b0;
      out_last_k <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      a_data     <= a_d;
      b_data     <= b_d;
      out_valid  <= valid_d;
      out_last_k <= last_k_d;
      out_last   <= last_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Next-state, index walk and next beat selection
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    a_d       = a_data;
    b_d       = b_data;
    valid_d   = out_valid;
    last_k_d  = out_last_k;
    last_d    = out_last;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_beat = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            n_d     = matrix_size;
            row_d   = '0;
            col_d   = '0;
            k_d     = '0;
            state_d = STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (!out_valid) begin
          load_beat = 1'b1;
        end else if (out_ready) begin
          if (is_last) begin
            valid_d  = 1'b0;
            last_k_d = 1'b0;
            last_d   = 1'b0;
            state_d  = DONE;
          end else begin
            load_beat = 1'b1;
            if (k_q == nm1) begin
              k_d = '0;
              if (col_q == nm1) begin
                col_d = '0;
                row_d = row_q + IDX_W'(1);
              end else begin
                col_d = col_q + IDX_W'(1);
              end
            end else begin
              k_d = k_q + IDX_W'(1);
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_beat) begin
      a_d      = buf_a[addr_of(row_d, k_d)];
      b_d      = buf_b[addr_of(k_d, col_d)];
      valid_d  = 1'b1;
      last_k_d = (k_d == nm1);
      last_d   = (row_d == nm1) && (col_d == nm1) && (k_d == nm1);
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_matrix_operand_fetch.sv
// Testbench for matrix_operand_fetch: directed steps with a beat scoreboard.
module tb_matrix_operand_fetch;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAX_N  = 8;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              lk;
    logic              l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en, load_sel;
  logic [3:0]        load_row, load_col;
  logic [DATA_W-1:0] load_data;
  logic              start;
  logic [3:0]        matrix_size;
  logic [DATA_W-1:0] a_data, b_data;
  logic              out_valid, out_ready, out_last_k, out_last;
  logic              busy, done, err;

  int compared   = 0;
  int mismatched = 0;
  int beats_seen = 0;
  bit mon_en     = 1'b0;
  bit hold_pend  = 1'b0;
  beat_t held;
  beat_t sb [$];
  logic [DATA_W-1:0] ma [MAX_N][MAX_N];
  logic [DATA_W-1:0] mb [MAX_N][MAX_N];

  matrix_operand_fetch #(.DATA_W(DATA_W), .MAX_N(MAX_N)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel),
    .load_row(load_row), .load_col(load_col), .load_data(load_data),
    .start(start), .matrix_size(matrix_size), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last_k(out_last_k),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops on each transfer, checks stability during stalls
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (hold_pend) begin
        check("stall_valid", 80'(out_valid), 80'(1));
        check("stall_beat", {a_data, b_data, out_last_k, out_last},
              {held.a, held.b, held.lk, held.l});
      end
      hold_pend = 1'b0;
      if (out_valid) begin
        if (!out_ready) begin
          hold_pend = 1'b1;
          held = '{a_data, b_data, out_last_k, out_last};
        end else begin
          beat_t e;
          beats_seen++;
          if (sb.size() == 0) begin
            check("extra_beat", 80'(out_valid), 80'(0));
          end else begin
            e = sb.pop_front();
            check("beat", {a_data, b_data, out_last_k, out_last},
                  {e.a, e.b, e.lk, e.l});
          end
        end
      end
    end
  end

  task automatic load(input logic sel, input logic [3:0] r, input logic [3:0] c,
                      input logic [DATA_W-1:0] d, input bit accepted);
    load_en = 1'b1; load_sel = sel; load_row = r; load_col = c; load_data = d;
    step();
    load_en = 1'b0;
    if (accepted) begin
      if (sel) mb[r][c] = d;
      else     ma[r][c] = d;
    end
  endtask

  task automatic push_expected(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int k = 0; k < n; k++)
          sb.push_back('{ma[r][k], mb[k][c], (k == n-1),
                         (r == n-1) && (c == n-1) && (k == n-1)});
  endtask

  // One full run: stall_mode applies a 1,0,0 ready pattern, mid_write
  // attempts to overwrite A[0][0] while streaming.
  task automatic run(input int n, input bit stall_mode, input bit mid_write);
    bit finished = 1'b0;
    push_expected(n);
    beats_seen = 0;
    start = 1'b1; matrix_size = 4'(n);
    step();
    start = 1'b0;
    check("start_busy", 80'(busy), 80'(1));
    check("start_valid", 80'(out_valid), 80'(0));
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      out_ready = stall_mode ? ((cyc % 3) == 0) : 1'b1;
      if (mid_write && cyc == 2) begin
        load_en = 1'b1; load_sel = 1'b0; load_row = 4'd0; load_col = 4'd0;
        load_data = 32'hFF;
      end else begin
        load_en = 1'b0;
      end
      step();
      if (cyc == 0) check("first_beat_valid", 80'(out_valid), 80'(1));
      if (done) finished = 1'b1;
    end
    load_en = 1'b0;
    check("done_pulse", 80'(done), 80'(1));
    check("end_state", {busy, out_valid}, 80'(0));
    check("beat_count", 80'(beats_seen), 80'(n * n * n));
    check("sb_empty", 80'(sb.size()), 80'(0));
    step();
    check("done_one_cycle", 80'(done), 80'(0));
    out_ready = 1'b1;
  endtask

  task automatic bad_start(input logic [3:0] n);
    start = 1'b1; matrix_size = n;
    step();
    start = 1'b0;
    check("err_pulse", 80'(err), 80'(1));
    check("err_idle", {busy, out_valid}, 80'(0));
    step();
    check("err_one_cycle", {err, busy, out_valid}, 80'(0));
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_row = '0; load_col = '0;
    load_data = '0; start = 1'b0; matrix_size = '0; out_ready = 1'b1;
    for (int r = 0; r < int'(MAX_N); r++)
      for (int c = 0; c < int'(MAX_N); c++) begin
        ma[r][c] = 'x;
        mb[r][c] = 'x;
      end
    step(); step();
    rst = 1'b0;
    check("reset_outputs",
          {a_data, b_data, out_valid, out_last_k, out_last, busy, done, err}, 80'(0));
    mon_en = 1'b1;

    load(0, 0, 0, 1, 1); load(0, 0, 1, 2, 1); load(0, 1, 0, 3, 1); load(0, 1, 1, 4, 1);
    load(1, 0, 0, 5, 1); load(1, 0, 1, 6, 1); load(1, 1, 0, 7, 1); load(1, 1, 1, 8, 1);

    run(2, 1'b0, 1'b0);
    run(2, 1'b1, 1'b0);

    load(0, 0, 0, 9, 1); load(1, 0, 0, 3, 1);
    run(1, 1'b0, 1'b0);

    bad_start(4'd0);
    bad_start(4'd9);

    load(0, 0, 0, 32'hAA, 1);
    run(2, 1'b0, 1'b1);
    load(0, 4'd8, 0, 32'h55, 0);
    run(2, 1'b1, 1'b0);

    // Reset after the third beat transfers
    push_expected(2);
    beats_seen = 0;
    start = 1'b1; matrix_size = 4'd2;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && beats_seen < 3; cyc++) step();
    check("beats_before_rst", 80'(beats_seen), 80'(3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_reset",
          {a_data, b_data, out_valid, out_last_k, out_last, busy, done, err}, 80'(0));
    sb.delete();
    hold_pend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_done_after_rst", {done, busy, out_valid}, 80'(0));
    end
    run(2, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
